proj_topk_sorter: RTL and testbench
===================================

PROJ_TOPK_SORTER -- requirements
Module: proj_topk_sorter

Interface
REQ-001 Parameter INDICES_COUNT, default proj_pkg::SORTER_EXTENDER_INDICES_COUNT, number of smallest entries kept (K >= 1).
REQ-002 Parameter INDICE_LEN, default proj_pkg::INDICE_LEN, index width.
REQ-003 Parameter SIGNATURE_LEN, default proj_pkg::HASHER_SORTER_SIGNATURE, signature width.
REQ-004 Parameter DEDUP, default proj_pkg::SORTER_DEDUP (0), 1 = drop beats whose signature equals a held valid entry.
REQ-005 in_clk  input  1  single clock; all state on rising edge.
REQ-006 in_rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  module accepts beat this cycle.
REQ-009 in_signature  input  SIGNATURE_LEN  beat signature.
REQ-010 in_index  input  INDICE_LEN  beat index.
REQ-011 in_last  input  1  beat is final of current frame (document).
REQ-012 out_valid  output  1  sorted result of completed frame available.
REQ-013 out_ready  output-side input  1  consumer takes result.
REQ-014 out_smallest_idx  output  [INDICES_COUNT][INDICE_LEN]  indices, slot 0 = smallest signature.
REQ-015 out_count  output  $clog2(INDICES_COUNT+1)  number of valid slots, saturates at K.

Function
REQ-016 FSM states S_ACCUM, S_OUT; in_ready = (state==S_ACCUM), out_valid = (state==S_OUT), both registered-state decodes.
REQ-017 Beat accepted when in_valid && in_ready; non-accepted cycles leave table unchanged.
REQ-018 Table: K slots of {signature, index, valid}, kept sorted ascending by signature, valid slots contiguous from slot 0.
REQ-019 Accepted beat inserts at first slot p where slot invalid or slot.signature > in_signature (strict); slots p..K-2 shift up one, slot K-1 discarded; no p -> beat dropped.
REQ-020 Ties: equal signature inserts after existing equal entries (first-arrival wins, stable).
REQ-021 DEDUP=1: beat whose signature equals any valid slot is dropped, table and out_count unchanged.
REQ-022 out_count increments by 1 per inserted beat while below K, never exceeds K.
REQ-023 Accepted beat with in_last=1: inserted same as REQ-019, state -> S_OUT next cycle; result includes that beat (latency 1 cycle from last beat to out_valid).
REQ-024 S_OUT: out_smallest_idx/out_count stable while out_valid && !out_ready; in_valid ignored.
REQ-025 S_OUT with out_ready=1: next cycle state S_ACCUM, all slots invalid, signatures '1, indices 0, out_count 0.
REQ-026 Invalid slots drive out_smallest_idx = 0 at all times.
REQ-027 Signature all-ones is a legal value; validity comes from valid bit, not sentinel.
REQ-028 Frame of 1 beat with in_last: out_count=1, slot 0 = that index.

Reset
REQ-029 in_rst_n=0 at a rising edge: state S_ACCUM, all slots invalid, signatures '1, indices 0, out_count 0; in_ready=1, out_valid=0 next cycle.
REQ-030 Reset mid-frame or during S_OUT discards the partial/pending result; no beat accepted in a reset cycle.

Structure
REQ-031 proj_pkg holds signature_index_pack (reused), new sorter_slot_t {signature_index_pack, valid}, sorter_state_e enum, SORTER_DEDUP constant.
REQ-032 One sub-module proj_topk_cell: one slot compare/select (keep, take new, take lower neighbour), instantiated K times via generate.
REQ-033 Insertion is single-cycle combinational across slots; no multicycle paths.

Verification (K=4, SIGNATURE_LEN=8, DEDUP=0 unless stated)
REQ-034 Signatures 50,20,80,10,30 (idx 1..5), last on idx5 -> out_valid next cycle, idx {4,2,5,1}, out_count=4.
REQ-035 Two beats sig 7 idx 3 then sig 7 idx 9, last -> idx {3,9,0,0}, out_count=2; same with DEDUP=1 -> {3,0,0,0}, out_count=1.
REQ-036 out_ready held 0 for 5 cycles in S_OUT with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next cycle out_count=0, next frame unaffected by old entries.
REQ-037 Signature 0xFF idx 6 alone with last -> out_count=1, slot 0 index 6.
REQ-038 Reset asserted after 3 beats of a frame -> out_valid=0, out_count=0; following frame 40,10 last -> {idx of 10, idx of 40}.
REQ-039 Random in_valid gaps, 1000 beats, 20 frames vs. reference model sort-and-take-K -> exact match every frame.

Source files
------------

// File: rtl/proj_pkg.sv
// proj_pkg: shared widths, slot types and sorter state encoding.
package proj_pkg;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN = 8;
  localparam int HASHER_SORTER_SIGNATURE = 8;
  localparam int SORTER_DEDUP = 0;
  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] signature;
    logic [INDICE_LEN-1:0] index;
  } signature_index_pack;
  typedef struct packed {
    signature_index_pack entry;
    logic valid;
  } sorter_slot_t;
  typedef enum logic {S_ACCUM, S_OUT} sorter_state_e;
endpackage

// File: rtl/proj_topk_cell.sv
// proj_topk_cell: one sorted-table slot; keeps, takes the new beat, or takes its lower neighbour.
module proj_topk_cell #(
  parameter int SIGNATURE_LEN = 8,
  parameter int INDICE_LEN = 8
) (
  input  logic                     i_en,
  input  logic [SIGNATURE_LEN-1:0] i_new_sig,
  input  logic [INDICE_LEN-1:0]    i_new_idx,
  input  logic                     i_prev_gt,
  input  logic                     i_lo_valid,
  input  logic [SIGNATURE_LEN-1:0] i_lo_sig,
  input  logic [INDICE_LEN-1:0]    i_lo_idx,
  input  logic                     i_valid,
  input  logic [SIGNATURE_LEN-1:0] i_sig,
  input  logic [INDICE_LEN-1:0]    i_idx,
  output logic                     o_gt,
  output logic                     o_eq,
  output logic                     o_valid,
  output logic [SIGNATURE_LEN-1:0] o_sig,
  output logic [INDICE_LEN-1:0]    o_idx
);
  logic w_take_new, w_take_lo;
  // Strict compare places equal signatures after existing ones; the table is
  // sorted, so o_gt is monotonic across slots and i_prev_gt marks the shift region.
  assign o_gt = !i_valid || (i_sig > i_new_sig);
  assign o_eq = i_valid && (i_sig == i_new_sig);
  assign w_take_lo = i_en && i_prev_gt;
  assign w_take_new = i_en && o_gt && !i_prev_gt;
  assign o_valid = w_take_lo ? i_lo_valid : (w_take_new ? 1'b1 : i_valid);
  assign o_sig = w_take_lo ? i_lo_sig : (w_take_new ? i_new_sig : i_sig);
  assign o_idx = w_take_lo ? i_lo_idx : (w_take_new ? i_new_idx : i_idx);
endmodule

// File: rtl/proj_topk_sorter.sv
// proj_topk_sorter: streams beats of a frame into a K-deep ascending table and
// presents the K smallest-signature indices once the frame's last beat lands.
module proj_topk_sorter #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
  parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
  parameter int DEDUP = proj_pkg::SORTER_DEDUP
) (
  input  logic                                      in_clk,
  input  logic                                      in_rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SIGNATURE_LEN-1:0]                  in_signature,
  input  logic [INDICE_LEN-1:0]                     in_index,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]  out_smallest_idx,
  output logic [$clog2(INDICES_COUNT+1)-1:0]        out_count
);
  import proj_pkg::*;
  localparam int CW = $clog2(INDICES_COUNT + 1);
  sorter_state_e r_state, w_state_nxt;
  logic [SIGNATURE_LEN-1:0] r_sig [INDICES_COUNT];
  logic [INDICE_LEN-1:0]    r_idx [INDICES_COUNT];
  logic [INDICES_COUNT-1:0] r_valid;
  logic [CW-1:0]            r_count;
  logic [SIGNATURE_LEN-1:0] w_sig_nxt [INDICES_COUNT];
  logic [INDICE_LEN-1:0]    w_idx_nxt [INDICES_COUNT];
  logic [INDICES_COUNT-1:0] w_valid_nxt;
  logic [SIGNATURE_LEN-1:0] w_lo_sig [INDICES_COUNT];
  logic [INDICE_LEN-1:0]    w_lo_idx [INDICES_COUNT];
  logic [INDICES_COUNT-1:0] w_lo_valid;
  logic [INDICES_COUNT:0]   w_gt;
  logic [INDICES_COUNT-1:0] w_eq;
  logic w_accept, w_ins, w_clear, w_full;

  assign in_ready = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_OUT);
  assign out_count = r_count;
  assign w_accept = in_valid && in_ready;
  assign w_ins = w_accept && !((DEDUP != 0) && (|w_eq));
  assign w_full = (r_count == CW'(INDICES_COUNT));
  assign w_gt[0] = 1'b0;

  always_comb begin
    w_state_nxt = (r_state == S_ACCUM) ? ((w_accept && in_last) ? S_OUT : S_ACCUM)
                                       : (out_ready ? S_ACCUM : S_OUT);
    w_clear = (r_state == S_OUT) && out_ready;
  end

  genvar i;
  generate
    for (i = 0; i < INDICES_COUNT; i++) begin : g_cell
      if (i == 0) begin : g_first
        assign w_lo_valid[i] = 1'b0;
        assign w_lo_sig[i] = '1;
        assign w_lo_idx[i] = '0;
      end else begin : g_rest
        assign w_lo_valid[i] = r_valid[i-1];
        assign w_lo_sig[i] = r_sig[i-1];
        assign w_lo_idx[i] = r_idx[i-1];
      end
      proj_topk_cell #(.SIGNATURE_LEN(SIGNATURE_LEN), .INDICE_LEN(INDICE_LEN)) u_cell (
        .i_en(w_ins), .i_new_sig(in_signature), .i_new_idx(in_index), .i_prev_gt(w_gt[i]),
        .i_lo_valid(w_lo_valid[i]), .i_lo_sig(w_lo_sig[i]), .i_lo_idx(w_lo_idx[i]),
        .i_valid(r_valid[i]), .i_sig(r_sig[i]), .i_idx(r_idx[i]),
        .o_gt(w_gt[i+1]), .o_eq(w_eq[i]),
        .o_valid(w_valid_nxt[i]), .o_sig(w_sig_nxt[i]), .o_idx(w_idx_nxt[i])
      );
      assign out_smallest_idx[i] = r_valid[i] ? r_idx[i] : '0;
    end
  endgenerate

  always_ff @(posedge in_clk) begin
    r_state <= !in_rst_n ? S_ACCUM : w_state_nxt;
    if (!in_rst_n || w_clear) begin
      r_count <= '0;
      r_valid <= '0;
      for (int k = 0; k < INDICES_COUNT; k++) begin
        r_sig[k] <= '1;
        r_idx[k] <= '0;
      end
    end else begin
      r_count <= r_count + CW'(w_ins && !w_full);
      r_valid <= w_valid_nxt;
      for (int k = 0; k < INDICES_COUNT; k++) begin
        r_sig[k] <= w_sig_nxt[k];
        r_idx[k] <= w_idx_nxt[k];
      end
    end
  end
endmodule

// File: tb/tb_proj_topk_sorter.sv
// tb_proj_topk_sorter: directed and random frames against a sort-and-take-K model,
// one DUT without and one with duplicate dropping, sharing all inputs.
module tb_proj_topk_sorter;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_sig = 0, in_idx = 0;
  logic rdy0, ov0, rdy1, ov1;
  logic [3:0][7:0] idx0, idx1;
  logic [2:0] cnt0, cnt1;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q_sig[$], q_idx[$];
  logic [3:0][7:0] e_idx [2];
  logic [2:0] e_cnt [2];

  always #5 clk = ~clk;

  proj_topk_sorter #(.INDICES_COUNT(4), .INDICE_LEN(8), .SIGNATURE_LEN(8), .DEDUP(0)) u_d0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_signature(in_sig), .in_index(in_idx), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_smallest_idx(idx0), .out_count(cnt0));
  proj_topk_sorter #(.INDICES_COUNT(4), .INDICE_LEN(8), .SIGNATURE_LEN(8), .DEDUP(1)) u_d1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_signature(in_sig), .in_index(in_idx), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_smallest_idx(idx1), .out_count(cnt1));

  // Reference: optionally keep only the first beat per signature, then stable-sort and take 4.
  task automatic model();
    for (int d = 0; d < 2; d++) begin
      bit used [$];
      bit elig [$];
      e_idx[d] = '0;
      e_cnt[d] = 0;
      for (int n = 0; n < q_sig.size(); n++) begin
        bit ok = 1;
        if (d == 1) for (int m = 0; m < n; m++) if (q_sig[m] == q_sig[n]) ok = 0;
        elig.push_back(ok);
        used.push_back(0);
      end
      for (int k = 0; k < 4; k++) begin
        int best = -1;
        for (int n = 0; n < q_sig.size(); n++)
          if (elig[n] && !used[n] && (best < 0 || q_sig[n] < q_sig[best])) best = n;
        if (best >= 0) begin
          used[best] = 1;
          e_idx[d][k] = q_idx[best];
          e_cnt[d] = e_cnt[d] + 1;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] i, input logic l);
    in_valid = 1; in_sig = s; in_idx = i; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    q_sig.push_back(s); q_idx.push_back(i);
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    q_sig.delete(); q_idx.delete();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rdy0 !== 1 || ov0 !== 0 || cnt0 !== 0 || idx0 !== '0 || rdy1 !== 1 || ov1 !== 0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b ov=%b cnt=%0d idx=%h want rdy=1 ov=0 cnt=0 idx=0", rdy0, ov0, cnt0, idx0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] s [5] = '{50, 20, 80, 10, 30};
    for (int n = 0; n < 5; n++) send(s[n], 8'(n + 1), n == 4);
    n_cmp++;
    if (ov0 !== 1 || rdy0 !== 0 || idx0 !== {8'd1, 8'd5, 8'd2, 8'd4} || cnt0 !== 3'd4) begin
      n_bad++;
      $display("FAIL basic: ov=%b rdy=%b idx=%h cnt=%0d want ov=1 rdy=0 idx=01050204 cnt=4", ov0, rdy0, idx0, cnt0);
    end
    drain();
  endtask

  task automatic test_ties();
    send(7, 3, 0);
    send(7, 9, 1);
    n_cmp++;
    if (idx0 !== {8'd0, 8'd0, 8'd9, 8'd3} || cnt0 !== 3'd2) begin
      n_bad++;
      $display("FAIL ties_nodedup: idx=%h cnt=%0d want 00000903 cnt=2", idx0, cnt0);
    end
    n_cmp++;
    if (ov1 !== 1 || idx1 !== {8'd0, 8'd0, 8'd0, 8'd3} || cnt1 !== 3'd1) begin
      n_bad++;
      $display("FAIL ties_dedup: ov=%b idx=%h cnt=%0d want ov=1 00000003 cnt=1", ov1, idx1, cnt1);
    end
    drain();
  endtask

  task automatic test_hold();
    send(9, 11, 0);
    send(4, 12, 0);
    send(6, 13, 1);
    model();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_sig = 8'($urandom_range(0, 3)); in_idx = 8'($urandom); in_last = 1;
      @(posedge clk); #1;
      n_cmp++;
      if (rdy0 !== 0 || ov0 !== 1 || idx0 !== e_idx[0] || cnt0 !== e_cnt[0]) begin
        n_bad++;
        $display("FAIL hold c%0d: rdy=%b ov=%b idx=%h cnt=%0d want rdy=0 ov=1 idx=%h cnt=%0d",
                 c, rdy0, ov0, idx0, cnt0, e_idx[0], e_cnt[0]);
      end
    end
    in_valid = 0; in_last = 0;
    drain();
    n_cmp++;
    if (ov0 !== 0 || rdy0 !== 1 || cnt0 !== 0 || idx0 !== '0) begin
      n_bad++;
      $display("FAIL release: ov=%b rdy=%b cnt=%0d idx=%h want ov=0 rdy=1 cnt=0 idx=0", ov0, rdy0, cnt0, idx0);
    end
    send(200, 21, 1);
    n_cmp++;
    if (idx0 !== {8'd0, 8'd0, 8'd0, 8'd21} || cnt0 !== 3'd1) begin
      n_bad++;
      $display("FAIL after_release: idx=%h cnt=%0d want 00000015 cnt=1", idx0, cnt0);
    end
    drain();
  endtask

  task automatic test_allones();
    send(8'hFF, 6, 1);
    n_cmp++;
    if (ov0 !== 1 || idx0 !== {8'd0, 8'd0, 8'd0, 8'd6} || cnt0 !== 3'd1) begin
      n_bad++;
      $display("FAIL allones: ov=%b idx=%h cnt=%0d want ov=1 00000006 cnt=1", ov0, idx0, cnt0);
    end
    drain();
  endtask

  task automatic test_midreset();
    send(5, 31, 0);
    send(3, 32, 0);
    send(8, 33, 0);
    rst_n = 0; in_valid = 1; in_sig = 1; in_idx = 99; in_last = 1;
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0; in_last = 0;
    q_sig.delete(); q_idx.delete();
    n_cmp++;
    if (ov0 !== 0 || cnt0 !== 0 || rdy0 !== 1 || idx0 !== '0) begin
      n_bad++;
      $display("FAIL midreset: ov=%b cnt=%0d rdy=%b idx=%h want ov=0 cnt=0 rdy=1 idx=0", ov0, cnt0, rdy0, idx0);
    end
    send(40, 41, 0);
    send(10, 42, 1);
    n_cmp++;
    if (idx0 !== {8'd0, 8'd0, 8'd41, 8'd42} || cnt0 !== 3'd2) begin
      n_bad++;
      $display("FAIL post_reset_frame: idx=%h cnt=%0d want 0000292a cnt=2", idx0, cnt0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      for (int b = 0; b < 50; b++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_sig = 8'($urandom); in_idx = 8'($urandom); in_last = 1'($urandom);
          @(posedge clk); #1;
          in_last = 0;
        end
        send(($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 40)), 8'($urandom), b == 49);
      end
      model();
      n_cmp++;
      if (ov0 !== 1 || idx0 !== e_idx[0] || cnt0 !== e_cnt[0]) begin
        n_bad++;
        $display("FAIL random f%0d dedup0: ov=%b idx=%h cnt=%0d want ov=1 idx=%h cnt=%0d",
                 f, ov0, idx0, cnt0, e_idx[0], e_cnt[0]);
      end
      n_cmp++;
      if (ov1 !== 1 || idx1 !== e_idx[1] || cnt1 !== e_cnt[1]) begin
        n_bad++;
        $display("FAIL random f%0d dedup1: ov=%b idx=%h cnt=%0d want ov=1 idx=%h cnt=%0d",
                 f, ov1, idx1, cnt1, e_idx[1], e_cnt[1]);
      end
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        in_valid = 1; in_sig = 0; in_idx = 8'($urandom);
        @(posedge clk); #1;
        in_valid = 0;
      end
      drain();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    test_basic();
    test_ties();
    test_hold();
    test_allones();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
